softex_slot_regfile: RTL
========================

Name: softex_slot_regfile

Overview:
- Responder side of the slot request/update protocol.
- The controller issues ALLOC/LOAD requests and UPDATE/FREE operations. This block owns slot storage (per-lane running maximum and denominator), allocates free slots, serves loads, and commits updates.
- Sits between the softex controller and the datapath lanes. Replaces the external slot cache for small on-chip slot counts.

Parameters:
- N_SLOTS, 4, number of physical slots (≥2, ≤ 2**ADDR_W).
- ADDR_W, 8, slot address width.
- NUM_LANES, 4, lanes per slot.
- WIDTH_IN, 16, per-lane maximum width (FP16ALT).
- WIDTH_ACC, 32, per-lane denominator width (FP32).
- MAX_INIT, 16'hFF80, reset/alloc value of each maximum lane (FP16ALT −inf).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  soft clear; same effect as reset on state
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  1  0=ALLOC, 1=LOAD
- req_addr_i  in  ADDR_W  slot address; LOAD only
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_addr_o  out  ADDR_W  allocated or loaded address
- rsp_max_o  out  NUM_LANES*WIDTH_IN  slot maxima, lane 0 in LSBs
- rsp_den_o  out  NUM_LANES*WIDTH_ACC  slot denominators
- rsp_slot_valid_o  out  1  slot has received ≥1 UPDATE
- rsp_err_o  out  1  request failed
- upd_valid_i  in  1  update valid; always accepted
- upd_op_i  in  1  0=UPDATE, 1=FREE
- upd_addr_i  in  ADDR_W  target slot
- upd_max_i  in  NUM_LANES*WIDTH_IN  new maxima
- upd_den_i  in  NUM_LANES*WIDTH_ACC  new denominators
- upd_err_o  out  1  one-cycle pulse: update targeted an unallocated/out-of-range slot
- n_alloc_o  out  $clog2(N_SLOTS+1)  number of allocated slots

Behaviour:

Reset / clear
- Applies on rising edge with rst_ni=0 or clear_i=1.
- All alloc bits and slot-valid bits are 0. Maxima = MAX_INIT. Denominators = 0.
- rsp_valid_o=0, rsp_* data=0, upd_err_o=0, n_alloc_o=0.
- An in-flight response is dropped.

Response register
- One-entry output register, latency 1.
- req_ready_o = !rsp_valid_o || rsp_ready_i.
- A request is accepted when req_valid_i && req_ready_o. The response appears the next cycle.
- rsp_* is held stable while rsp_valid_o && !rsp_ready_i.
- Back-to-back accepts give one response per cycle.

ALLOC
- Selects the lowest-index slot whose alloc bit was 0 at the start of the cycle.
- Sets its alloc bit. Re-initialises it: maxima=MAX_INIT, den=0, slot_valid=0.
- Response: rsp_addr_o=index, rsp_err_o=0, data = initialised values.
- No free slot: rsp_err_o=1, rsp_addr_o=0, data=0, no state change.

LOAD
- Valid target: addr < N_SLOTS and allocated. Response carries stored contents, err=0.
- Otherwise: rsp_err_o=1, data=0, rsp_addr_o=req_addr_i.

UPDATE
- Target allocated and in range: writes max/den and sets slot_valid=1 at the clock edge.
- Otherwise: no write and upd_err_o=1 next cycle.

FREE
- Clears the alloc and slot_valid bits. Data is left as is.
- FREE of an unallocated slot: upd_err_o=1, no state change.

Simultaneous events
- UPDATE and LOAD to the same addr in the same cycle: the response returns the new upd data (write-through bypass).
- FREE and LOAD to the same addr in the same cycle: rsp_err_o=1.
- FREE and ALLOC in the same cycle: the freed slot is not eligible for that ALLOC. It is eligible from the next cycle.
- UPDATE to the slot being ALLOCated in the same cycle: upd_err_o=1, because alloc is judged on pre-cycle state.

Counter
- n_alloc_o tracks popcount of the alloc bits, registered.
- Changes by at most +1/−1 per cycle. A simultaneous ALLOC-success and FREE-success leaves it unchanged.

Test Plan:
- Reset, then 4 ALLOCs back-to-back with rsp_ready_i=1 → rsp_addr_o 0,1,2,3 on consecutive cycles, err=0, maxima all 16'hFF80, n_alloc_o=4.
- 5th ALLOC with all slots full → rsp_err_o=1, rsp_addr_o=0, n_alloc_o stays 4. Then FREE slot 2 and ALLOC → addr 2.
- UPDATE slot 1 with max lanes {3F80,4000,4040,4080}, den lanes 32'h3F800000, then LOAD 1 → exact data, rsp_slot_valid_o=1. LOAD 3, never updated → slot_valid=0, err=0.
- Hold rsp_ready_i=0 for 3 cycles with req_valid_i=1 → req_ready_o=0, response stable, exactly one request consumed on release.
- Same-cycle UPDATE and LOAD slot 0 → response shows new data. Same-cycle FREE 0 and LOAD 0 → err=1. UPDATE addr 7 (N_SLOTS=4) → upd_err_o pulses one cycle.
- Assert clear_i with a pending, stalled response → rsp_valid_o=0 next cycle, n_alloc_o=0, next ALLOC returns addr 0.

Source files
------------

// File: rtl/softex_slot_regfile.sv
// Slot register file: responder side of the slot request/update protocol.
// Holds per-slot running maxima and denominators. Allocates free slots,
// serves loads through a one-entry response register, and commits
// updates and frees from the controller.
module softex_slot_regfile #(
  parameter int                  N_SLOTS   = 4,
  parameter int                  ADDR_W    = 8,
  parameter int                  NUM_LANES = 4,
  parameter int                  WIDTH_IN  = 16,
  parameter int                  WIDTH_ACC = 32,
  parameter logic [WIDTH_IN-1:0] MAX_INIT  = 16'hFF80
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_op_i,
  input  logic [ADDR_W-1:0]              req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ADDR_W-1:0]              rsp_addr_o,
  output logic [NUM_LANES*WIDTH_IN-1:0]  rsp_max_o,
  output logic [NUM_LANES*WIDTH_ACC-1:0] rsp_den_o,
  output logic                           rsp_slot_valid_o,
  output logic                           rsp_err_o,
  input  logic                           upd_valid_i,
  input  logic                           upd_op_i,
  input  logic [ADDR_W-1:0]              upd_addr_i,
  input  logic [NUM_LANES*WIDTH_IN-1:0]  upd_max_i,
  input  logic [NUM_LANES*WIDTH_ACC-1:0] upd_den_i,
  output logic                           upd_err_o,
  output logic [$clog2(N_SLOTS+1)-1:0]   n_alloc_o
);

  localparam int IDX_W = $clog2(N_SLOTS);
  localparam int CNT_W = $clog2(N_SLOTS+1);
  localparam int MW    = NUM_LANES*WIDTH_IN;
  localparam int DW    = NUM_LANES*WIDTH_ACC;
  localparam logic [ADDR_W:0] N_SLOTS_W = (ADDR_W+1)'(N_SLOTS);

  logic [N_SLOTS-1:0] r_alloc;
  logic [N_SLOTS-1:0] r_sval;
  logic [MW-1:0]      r_max [N_SLOTS];
  logic [DW-1:0]      r_den [N_SLOTS];
  logic [CNT_W-1:0]   r_n_alloc;

  logic               r_rsp_valid;
  logic [ADDR_W-1:0]  r_rsp_addr;
  logic [MW-1:0]      r_rsp_max;
  logic [DW-1:0]      r_rsp_den;
  logic               r_rsp_sval;
  logic               r_rsp_err;
  logic               r_upd_err;

  logic [MW-1:0]      w_max_init;
  logic [IDX_W-1:0]   w_req_idx, w_upd_idx, w_free_idx;
  logic               w_req_in_range, w_upd_in_range, w_free_found;
  logic               w_accept, w_do_alloc, w_upd_hit, w_upd_write, w_free_ok;
  logic               w_same_addr, w_load_ok, w_load_bypass;
  logic [ADDR_W-1:0]  w_rsp_addr;
  logic [MW-1:0]      w_rsp_max;
  logic [DW-1:0]      w_rsp_den;
  logic               w_rsp_sval, w_rsp_err;

  assign w_max_init     = {NUM_LANES{MAX_INIT}};
  assign w_req_idx      = req_addr_i[IDX_W-1:0];
  assign w_upd_idx      = upd_addr_i[IDX_W-1:0];
  assign w_req_in_range = {1'b0, req_addr_i} < N_SLOTS_W;
  assign w_upd_in_range = {1'b0, upd_addr_i} < N_SLOTS_W;

  assign req_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;

  // Lowest-index free slot, judged on the alloc bits held at cycle start.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = N_SLOTS-1; i >= 0; i--) begin
      if (!r_alloc[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_do_alloc    = w_accept && !req_op_i && w_free_found;
  assign w_upd_hit     = upd_valid_i && w_upd_in_range && r_alloc[w_upd_idx];
  assign w_upd_write   = w_upd_hit && !upd_op_i;
  assign w_free_ok     = w_upd_hit && upd_op_i;
  assign w_same_addr   = upd_addr_i == req_addr_i;
  assign w_load_ok     = w_req_in_range && r_alloc[w_req_idx] && !(w_free_ok && w_same_addr);
  assign w_load_bypass = w_upd_write && w_same_addr;

  // Next response contents for an accepted request; loads see a same-cycle update.
  always_comb begin
    w_rsp_addr = '0;
    w_rsp_max  = '0;
    w_rsp_den  = '0;
    w_rsp_sval = 1'b0;
    w_rsp_err  = 1'b0;
    if (!req_op_i) begin
      if (w_free_found) begin
        w_rsp_addr = ADDR_W'(w_free_idx);
        w_rsp_max  = w_max_init;
      end else begin
        w_rsp_err = 1'b1;
      end
    end else begin
      w_rsp_addr = req_addr_i;
      if (!w_load_ok) begin
        w_rsp_err = 1'b1;
      end else if (w_load_bypass) begin
        w_rsp_max  = upd_max_i;
        w_rsp_den  = upd_den_i;
        w_rsp_sval = 1'b1;
      end else begin
        w_rsp_max  = r_max[w_req_idx];
        w_rsp_den  = r_den[w_req_idx];
        w_rsp_sval = r_sval[w_req_idx];
      end
    end
  end

  // Slot storage: alloc re-init, update writes, frees clear bookkeeping only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_alloc <= '0;
      r_sval  <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_max[i] <= w_max_init;
        r_den[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_do_alloc && w_free_idx == IDX_W'(i)) begin
          r_alloc[i] <= 1'b1;
          r_sval[i]  <= 1'b0;
          r_max[i]   <= w_max_init;
          r_den[i]   <= '0;
        end else if (w_upd_write && w_upd_idx == IDX_W'(i)) begin
          r_sval[i] <= 1'b1;
          r_max[i]  <= upd_max_i;
          r_den[i]  <= upd_den_i;
        end else if (w_free_ok && w_upd_idx == IDX_W'(i)) begin
          r_alloc[i] <= 1'b0;
          r_sval[i]  <= 1'b0;
        end
      end
    end
  end

  // One-entry response register, held while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_max   <= '0;
      r_rsp_den   <= '0;
      r_rsp_sval  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= w_rsp_addr;
      r_rsp_max   <= w_rsp_max;
      r_rsp_den   <= w_rsp_den;
      r_rsp_sval  <= w_rsp_sval;
      r_rsp_err   <= w_rsp_err;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Update error pulse and allocated-slot count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_upd_err <= 1'b0;
      r_n_alloc <= '0;
    end else begin
      r_upd_err <= upd_valid_i && !w_upd_hit;
      case ({w_do_alloc, w_free_ok})
        2'b10:   r_n_alloc <= r_n_alloc + 1'b1;
        2'b01:   r_n_alloc <= r_n_alloc - 1'b1;
        default: r_n_alloc <= r_n_alloc;
      endcase
    end
  end

  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_addr_o       = r_rsp_addr;
  assign rsp_max_o        = r_rsp_max;
  assign rsp_den_o        = r_rsp_den;
  assign rsp_slot_valid_o = r_rsp_sval;
  assign rsp_err_o        = r_rsp_err;
  assign upd_err_o        = r_upd_err;
  assign n_alloc_o        = r_n_alloc;

endmodule
